// File: rtl/data_mem_ctrl_pkg.sv
// Shared defaults for the data-side memory controller.
package data_mem_ctrl_pkg;

  // Data and address width of the CPU data port.
  localparam int unsigned WORD_WIDTH = 32;

  // Data RAM depth as log2 of the word count.
  localparam int unsigned DMEM_ADDR_LOG2 = 10;

  // Store-buffer entries; must be a power of two and at least 2.
  localparam int unsigned DMEM_SB_DEPTH = 4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU MEM-stage load/store port bundle for the data memory controller.
interface data_mem_ctrl_if #(
  parameter int unsigned W        = 32,
  parameter int unsigned SB_DEPTH = 4
);

  logic                        load_en;
  logic [W-1:0]                l_addr;
  logic [W-1:0]                l_data;
  logic                        store_en;
  logic [W-1:0]                s_addr;
  logic [W-1:0]                s_data;
  logic [$clog2(SB_DEPTH):0]   sb_count;
  logic                        sb_empty;
  logic                        sb_overflow;

  // CPU side drives requests.
  modport master (
    output load_en, l_addr, store_en, s_addr, s_data,
    input  l_data, sb_count, sb_empty, sb_overflow
  );

  // Controller side serves them.
  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data,
    output l_data, sb_count, sb_empty, sb_overflow
  );

endinterface

// File: rtl/data_mem_ctrl_store_buffer.sv
// In-order store buffer: circular FIFO of {word index, data} with youngest-match forwarding.
module data_mem_ctrl_store_buffer #(
  parameter int unsigned W     = 32,
  parameter int unsigned IDXW  = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_store_en,
  input  logic [IDXW-1:0]          i_s_idx,
  input  logic [W-1:0]             i_s_data,
  input  logic                     i_pop,
  input  logic [IDXW-1:0]          i_l_idx,
  output logic [IDXW-1:0]          o_head_idx,
  output logic [W-1:0]             o_head_data,
  output logic                     o_hit,
  output logic [W-1:0]             o_fwd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IDXW-1:0] r_idx  [DEPTH];
  logic [W-1:0]    r_data [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  // A drain in the same cycle frees the slot a full buffer needs.
  assign w_push  = i_store_en && (!w_full || w_pop);
  assign w_drop  = i_store_en && !w_push;

  // Pointers, occupancy and sticky overflow; reset discards pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_idx[r_wr_ptr]  <= i_s_idx;
      r_data[r_wr_ptr] <= i_s_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] w_slot;
    o_hit      = 1'b0;
    o_fwd_data = '0;
    w_slot     = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_slot = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_idx[w_slot] == i_l_idx)) begin
        o_hit      = 1'b1;
        o_fwd_data = r_data[w_slot];
      end
    end
  end

  assign o_head_idx  = r_idx[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: single-port RAM, store buffer drain and forwarded loads.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned W         = WORD_WIDTH,
  parameter int unsigned ADDR_LOG2 = DMEM_ADDR_LOG2,
  parameter int unsigned SB_DEPTH  = DMEM_SB_DEPTH
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  logic [W-1:0] r_mem [1 << ADDR_LOG2];
  logic [W-1:0] r_ram_rdata;
  logic         r_load_pending;
  logic         r_fwd_hit;
  logic [W-1:0] r_fwd_data;
  logic [W-1:0] r_l_data;

  logic [ADDR_LOG2-1:0]      w_l_idx;
  logic [ADDR_LOG2-1:0]      w_s_idx;
  logic [ADDR_LOG2-1:0]      w_head_idx;
  logic [W-1:0]              w_head_data;
  logic                      w_hit;
  logic [W-1:0]              w_fwd_data;
  logic                      w_sb_empty;
  logic                      w_drain;
  logic                      w_unused_addr_bits;

  assign w_l_idx = bus.l_addr[ADDR_LOG2+1:2];
  assign w_s_idx = bus.s_addr[ADDR_LOG2+1:2];

  // Byte offset and bits above the word index carry no meaning here.
  assign w_unused_addr_bits = ^{bus.l_addr[W-1:ADDR_LOG2+2], bus.l_addr[1:0],
                                bus.s_addr[W-1:ADDR_LOG2+2], bus.s_addr[1:0]};

  // The RAM port belongs to loads; drains only use load-free cycles.
  assign w_drain = !bus.load_en && !w_sb_empty && !rst;

  data_mem_ctrl_store_buffer #(
    .W     (W),
    .IDXW  (ADDR_LOG2),
    .DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .i_store_en  (bus.store_en),
    .i_s_idx     (w_s_idx),
    .i_s_data    (bus.s_data),
    .i_pop       (w_drain),
    .i_l_idx     (w_l_idx),
    .o_head_idx  (w_head_idx),
    .o_head_data (w_head_data),
    .o_hit       (w_hit),
    .o_fwd_data  (w_fwd_data),
    .o_count     (bus.sb_count),
    .o_empty     (w_sb_empty),
    .o_overflow  (bus.sb_overflow)
  );

  // Single-port RAM: read for a load, otherwise write back the buffer head.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      r_ram_rdata <= r_mem[w_l_idx];
    end else if (w_drain) begin
      r_mem[w_head_idx] <= w_head_data;
    end
  end

  // Load pipeline: capture forward result at request, pick source one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_pending <= 1'b0;
      r_fwd_hit      <= 1'b0;
      r_fwd_data     <= '0;
      r_l_data       <= '0;
    end else begin
      r_load_pending <= bus.load_en;
      if (bus.load_en) begin
        r_fwd_hit  <= w_hit;
        r_fwd_data <= w_fwd_data;
      end
      if (r_load_pending) begin
        r_l_data <= r_fwd_hit ? r_fwd_data : r_ram_rdata;
      end
    end
  end

  assign bus.l_data   = r_l_data;
  assign bus.sb_empty = w_sb_empty;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: forwarding, draining, overflow and reset.
module tb_data_mem_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  data_mem_ctrl_if #(.W(32), .SB_DEPTH(4)) bus ();

  data_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of request inputs and step past the sampling edge.
  task automatic cyc(input logic le, input logic [31:0] la, input logic se,
                     input logic [31:0] sa, input logic [31:0] sd);
    bus.load_en  = le;
    bus.l_addr   = la;
    bus.store_en = se;
    bus.s_addr   = sa;
    bus.s_data   = sd;
    tick();
    bus.load_en  = 1'b0;
    bus.store_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Single load then one more edge; l_data is valid after that second edge.
  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cyc(1'b1, addr, 1'b0, 32'h0, 32'h0);
    tick();
    check(tag, bus.l_data, exp);
  endtask

  initial begin
    logic [31:0] vals [5];
    n_checks = 0;
    n_pass   = 0;
    rst          = 1'b1;
    bus.load_en  = 1'b0;
    bus.l_addr   = '0;
    bus.store_en = 1'b0;
    bus.s_addr   = '0;
    bus.s_data   = '0;
    idle(2);
    rst = 1'b0;

    check("rst_l_data", bus.l_data, 32'h0);
    check("rst_count", 32'(bus.sb_count), 32'd0);
    check("rst_empty", 32'(bus.sb_empty), 32'd1);
    check("rst_ovf", 32'(bus.sb_overflow), 32'd0);

    // Plain store, drain, RAM load.
    cyc(1'b0, 32'h0, 1'b1, 32'h10, 32'h0000_1234);
    check("st1_count", 32'(bus.sb_count), 32'd1);
    idle(1);
    check("st1_drained", 32'(bus.sb_empty), 32'd1);
    load_chk("ld_0x10", 32'h10, 32'h0000_1234);

    // Forwarded load before drain, then RAM load after drain.
    cyc(1'b0, 32'h0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    cyc(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    check("fwd_blocks_drain", 32'(bus.sb_count), 32'd1);
    tick();
    check("ld_0x20_fwd", bus.l_data, 32'hDEAD_BEEF);
    check("drain_after_ld", 32'(bus.sb_count), 32'd0);
    load_chk("ld_0x20_ram", 32'h20, 32'hDEAD_BEEF);
    load_chk("ld_ignored_bits", 32'h0000_1023, 32'hDEAD_BEEF);

    // Two stores to one word while loads hold off the drain; youngest wins.
    cyc(1'b1, 32'h80, 1'b1, 32'h40, 32'h1);
    cyc(1'b1, 32'h80, 1'b1, 32'h40, 32'h2);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    check("two_st_count", 32'(bus.sb_count), 32'd2);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    check("b2b_count", 32'(bus.sb_count), 32'd2);
    check("b2b_ld1", bus.l_data, 32'h2);
    tick();
    check("b2b_ld2", bus.l_data, 32'h2);
    check("b2b_drain1", 32'(bus.sb_count), 32'd1);
    idle(1);
    load_chk("ld_0x40_ram", 32'h40, 32'h2);

    // Store-only stream: each store overlaps a drain.
    for (int i = 0; i < 5; i++) begin
      vals[i] = 32'hA0 + 32'(i);
      cyc(1'b0, 32'h0, 1'b1, 32'(4 * i), vals[i]);
    end
    check("stream_count", 32'(bus.sb_count), 32'd1);
    check("stream_ovf", 32'(bus.sb_overflow), 32'd0);
    idle(5);
    check("stream_empty", 32'(bus.sb_empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      load_chk($sformatf("stream_ram%0d", i), 32'(4 * i), vals[i]);
    end

    // Fill under loads, store into a full buffer with a drain, then drop one.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h200, 1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
    end
    check("fill_count", 32'(bus.sb_count), 32'd4);
    cyc(1'b0, 32'h0, 1'b1, 32'h114, 32'hC5);
    check("full_st_count", 32'(bus.sb_count), 32'd4);
    check("full_st_ovf", 32'(bus.sb_overflow), 32'd0);
    cyc(1'b1, 32'h110, 1'b1, 32'h110, 32'hBAD);
    check("drop_count", 32'(bus.sb_count), 32'd4);
    check("drop_ovf", 32'(bus.sb_overflow), 32'd1);
    tick();
    check("drop_ld_not_fwd", 32'(bus.l_data == 32'hBAD), 32'd0);
    idle(3);
    check("drop_drained", 32'(bus.sb_empty), 32'd1);
    check("ovf_sticky", 32'(bus.sb_overflow), 32'd1);
    load_chk("ld_0x114", 32'h114, 32'hC5);
    load_chk("ld_0x104", 32'h104, 32'hB1);

    // Reset with three pending entries discards them.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0, 1'b1, 32'(4 * i), 32'hE0 + 32'(i));
    end
    check("pend_count", 32'(bus.sb_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_count", 32'(bus.sb_count), 32'd0);
    check("rst2_empty", 32'(bus.sb_empty), 32'd1);
    check("rst2_ovf", 32'(bus.sb_overflow), 32'd0);
    check("rst2_l_data", bus.l_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      load_chk($sformatf("rst2_ram%0d", i), 32'(4 * i), vals[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
